// File: rtl/gunshot_pkg.sv
// rtl/gunshot_pkg.sv - shared constants and TX state type for the gunshot event reporter
package gunshot_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam logic [2:0] DIR_MAX     = 3'd5;
    localparam int         FIFO_DEPTH  = 4;
    localparam int         PAYLOAD_W   = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/gunshot_uart_byte_tx.sv
// rtl/gunshot_uart_byte_tx.sv - 8N1 byte serialiser; a byte offered during the last stop-bit cycle follows with no gap
module gunshot_uart_byte_tx
    import gunshot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_busy;
    logic             w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign o_ready   = (r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_end);
    assign o_tx      = r_tx;
    assign o_busy    = r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            // Line and busy flag follow the state one cycle later so both come straight from flops.
            case (r_state)
                TX_START: r_tx <= 1'b0;
                TX_DATA:  r_tx <= r_shift[0];
                default:  r_tx <= 1'b1;
            endcase
            r_busy <= (r_state != TX_IDLE);

            if (i_valid && o_ready) begin
                r_state <= TX_START;
                r_cnt   <= '0;
                r_shift <= i_data;
            end else begin
                case (r_state)
                    TX_START: begin
                        if (w_bit_end) begin
                            r_state <= TX_DATA;
                            r_cnt   <= '0;
                            r_bit   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    TX_DATA: begin
                        if (w_bit_end) begin
                            r_cnt   <= '0;
                            r_shift <= {1'b0, r_shift[7:1]};
                            if (r_bit == 3'd7) begin
                                r_state <= TX_STOP;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    TX_STOP: begin
                        if (w_bit_end) begin
                            r_state <= TX_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= TX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/gunshot_event_tx.sv
// rtl/gunshot_event_tx.sv - gunshot edge filter, holdoff, event FIFO and two-byte UART frame sequencer
module gunshot_event_tx
    import gunshot_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 434,
    parameter int HOLDOFF_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gunshot_detected,
    input  logic [2:0] direction,
    output logic       tx,
    output logic       tx_busy,
    output logic [7:0] drop_count
);

    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    logic                 r_prev;
    logic [HOLD_W-1:0]    r_holdoff;
    logic [4:0]           r_seq;
    logic [7:0]           r_drop_count;
    logic                 r_push_vld;
    logic [PAYLOAD_W-1:0] r_push_data;
    logic [PAYLOAD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic                 r_byte_idx;
    logic [PAYLOAD_W-1:0] r_payload;

    logic                 w_edge;
    logic                 w_locked;
    logic                 w_dir_bad;
    logic                 w_fifo_full;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_ser_valid;
    logic                 w_ser_ready;
    logic [7:0]           w_ser_data;
    logic                 w_pop;

    assign w_edge      = gunshot_detected && !r_prev;
    assign w_locked    = (r_holdoff != '0);
    assign w_dir_bad   = (direction > DIR_MAX);
    // A pop in the same cycle frees a slot, so a full FIFO still takes the new event.
    assign w_fifo_full = (r_count == (PTR_W+1)'(FIFO_DEPTH)) && !w_pop;
    assign w_accept    = w_edge && !w_locked && !w_dir_bad && !w_fifo_full;
    assign w_reject    = w_edge && !w_locked && (w_dir_bad || w_fifo_full);

    // Byte index 0 offers the header for the FIFO head; index 1 offers the popped payload.
    assign w_ser_valid = r_byte_idx || (r_count != '0);
    assign w_ser_data  = r_byte_idx ? r_payload : HEADER_BYTE;
    assign w_pop       = w_ser_valid && w_ser_ready && !r_byte_idx;
    assign drop_count  = r_drop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev       <= 1'b0;
            r_holdoff    <= '0;
            r_seq        <= '0;
            r_drop_count <= '0;
            r_push_vld   <= 1'b0;
            r_push_data  <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_byte_idx   <= 1'b0;
            r_payload    <= '0;
        end else begin
            r_prev <= gunshot_detected;

            if (w_accept) begin
                r_holdoff <= HOLD_W'(HOLDOFF_CYCLES);
            end else if (w_locked) begin
                r_holdoff <= r_holdoff - 1'b1;
            end

            if (w_reject && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end

            r_push_vld <= w_accept;
            if (w_accept) begin
                r_push_data <= {r_seq, direction};
                r_seq       <= r_seq + 1'b1;
            end

            if (r_push_vld) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_payload <= r_mem[r_rd_ptr];
            end
            r_count <= r_count + (PTR_W+1)'(r_push_vld) - (PTR_W+1)'(w_pop);

            if (w_ser_valid && w_ser_ready) begin
                r_byte_idx <= !r_byte_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_push_vld) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    gunshot_uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (clk),
        .reset   (reset),
        .i_data  (w_ser_data),
        .i_valid (w_ser_valid),
        .o_ready (w_ser_ready),
        .o_tx    (tx),
        .o_busy  (tx_busy)
    );

endmodule

// File: tb/tb_gunshot_event_tx.sv
// tb/tb_gunshot_event_tx.sv - randomized bench for gunshot_event_tx against an event-level reference model
module tb_gunshot_event_tx;
    import gunshot_pkg::*;

    localparam int CPB   = 4;
    localparam int HOLD  = 20;
    localparam int FRAME = 20 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       gunshot_detected = 1'b0;
    logic [2:0] direction = 3'd0;
    logic       tx;
    logic       tx_busy;
    logic [7:0] drop_count;

    always #5 clk = ~clk;

    gunshot_event_tx #(
        .CLKS_PER_BIT   (CPB),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .gunshot_detected (gunshot_detected),
        .direction        (direction),
        .tx               (tx),
        .tx_busy          (tx_busy),
        .drop_count       (drop_count)
    );

    int n_vec = 0;
    int n_miss = 0;
    int t = 0;

    // Reference state: pending events with the edge index from which they may be popped,
    // and frames with the edge index at which they were popped.
    logic m_prev = 1'b0;
    int   m_seq = 0;
    int   m_drop = 0;
    int   m_last_acc = -1000000;
    int   m_next_free = 0;
    int   q_pay[$];
    int   q_rdy[$];
    int   f_pt[$];
    int   f_pay[$];
    int   e_tx = 1;
    int   e_busy = 0;

    logic       gd_r = 1'b0;
    logic [2:0] dir_r = 3'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s @edge %0d: got 0x%0h, want 0x%0h", tag, t, obs, exp);
        end
    endtask

    function automatic int frame_bit(input int k, input int pay);
        int pos;
        int b;
        pos = k % 10;
        b = (k < 10) ? int'(HEADER_BYTE) : pay;
        if (pos == 0) return 0;
        if (pos == 9) return 1;
        return (b >> (pos - 1)) & 1;
    endfunction

    task automatic model_edge(input logic rst, input logic gd, input logic [2:0] dir);
        int pt;
        if (rst) begin
            m_prev = 1'b0;
            m_seq = 0;
            m_drop = 0;
            m_last_acc = -1000000;
            m_next_free = 0;
            q_pay.delete();
            q_rdy.delete();
            f_pt.delete();
            f_pay.delete();
        end else begin
            while (q_pay.size() > 0 && q_rdy[0] <= t && m_next_free <= t) begin
                pt = (q_rdy[0] > m_next_free) ? q_rdy[0] : m_next_free;
                f_pt.push_back(pt);
                f_pay.push_back(q_pay[0]);
                void'(q_pay.pop_front());
                void'(q_rdy.pop_front());
                m_next_free = pt + FRAME;
            end
            if (gd && !m_prev && t > m_last_acc + HOLD) begin
                if (dir > 3'd5 || q_pay.size() >= 4) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    q_pay.push_back(m_seq * 8 + int'(dir));
                    q_rdy.push_back(t + 2);
                    m_seq = (m_seq + 1) % 32;
                    m_last_acc = t;
                end
            end
            m_prev = gd;
        end
        while (f_pt.size() > 0 && f_pt[0] + FRAME < t) begin
            void'(f_pt.pop_front());
            void'(f_pay.pop_front());
        end
        if (f_pt.size() > 0 && f_pt[0] + 1 <= t) begin
            e_busy = 1;
            e_tx = frame_bit((t - f_pt[0] - 1) / CPB, f_pay[0]);
        end else begin
            e_busy = 0;
            e_tx = 1;
        end
    endtask

    task automatic step(input logic rst, input logic gd, input logic [2:0] dir);
        reset = rst;
        gunshot_detected = gd;
        direction = dir;
        @(posedge clk);
        t++;
        model_edge(rst, gd, dir);
        @(negedge clk);
        check("tx", tx, e_tx);
        check("tx_busy", tx_busy, e_busy);
        check("drop_count", drop_count, m_drop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0);

        // single event, direction 3
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd3);
        idle(100);

        // second edge 10 cycles after the first falls inside the holdoff
        step(1'b0, 1'b1, 3'd1);
        step(1'b0, 1'b1, 3'd1);
        idle(8);
        step(1'b0, 1'b1, 3'd4);
        idle(120);

        // illegal direction then a legal edge right after
        step(1'b0, 1'b1, 3'd6);
        step(1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b1, 3'd2);
        idle(100);

        // events faster than frames drain: FIFO fills and overflows
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 3'($urandom_range(0, 5)));
            idle(20);
        end
        idle(700);

        // reset mid-frame, then an edge in the first cycle after reset
        step(1'b0, 1'b1, 3'd5);
        idle(30);
        step(1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b1, 3'd1);
        step(1'b0, 1'b1, 3'd1);
        idle(100);

        // drop counter saturation
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b1, 3'd7);
            step(1'b0, 1'b0, 3'd0);
        end
        idle(5);
        step(1'b1, 1'b0, 3'd0);

        // random levels, directions and occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                gd_r = !gd_r;
                if (gd_r) dir_r = 3'($urandom_range(0, 7));
            end
            step(($urandom_range(0, 799) == 0), gd_r, dir_r);
        end
        idle(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
